// File: rtl/uart_rx_ctrl_pkg.sv
// Shared UART receive configuration: state encoding and legal prescale values.
// Build option UART_RX_MAJORITY_VOTE_EN (when defined) selects 3-sample majority voting in uart_rx_sampler.
package uart_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int unsigned PRESC_8       = 8;
  localparam int unsigned PRESC_16      = 16;
  localparam int unsigned PRESC_32      = 32;
  localparam int unsigned PRESC_DEFAULT = PRESC_8;

  function automatic logic prescale_legal(input int unsigned p);
    return (p == PRESC_8) || (p == PRESC_16) || (p == PRESC_32);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_sampler.sv
// Bit sampler for the UART receiver: decides each bit at edge P/2+1 and holds it until the next decision.
// UART_RX_MAJORITY_VOTE_EN defined: majority of edges P/2-1, P/2, P/2+1; otherwise the single edge P/2.
module uart_rx_sampler
  import uart_rx_ctrl_pkg::*;
#(
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [PRESC_W-1:0] edge_cnt,
  input  logic [PRESC_W-1:0] presc,
  input  logic               RX_IN,
  output logic               sampled_bit,
  output logic               decide
);

  logic [PRESC_W-1:0] half;
  logic               mid_q;
  logic               held_q;
  logic               bit_now;

  assign half   = presc >> 1;
  assign decide = (edge_cnt == half + PRESC_W'(1));

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic early_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      early_q <= 1'b1;
      mid_q   <= 1'b1;
    end else begin
      if (edge_cnt == half - PRESC_W'(1)) early_q <= RX_IN;
      if (edge_cnt == half)               mid_q   <= RX_IN;
    end
  end

  // Third vote is the live line value at the decision edge itself.
  assign bit_now = (early_q & mid_q) | (early_q & RX_IN) | (mid_q & RX_IN);
`else
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mid_q <= 1'b1;
    end else if (edge_cnt == half) begin
      mid_q <= RX_IN;
    end
  end

  assign bit_now = mid_q;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      held_q <= 1'b1;
    end else if (decide) begin
      held_q <= bit_now;
    end
  end

  assign sampled_bit = decide ? bit_now : held_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detect, LSB-first shift-in, optional parity and stop check.
// Sampling mode follows UART_RX_MAJORITY_VOTE_EN (see uart_rx_sampler).
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  rx_state_t             state_q, state_d;
  logic [PRESC_W-1:0]    edge_q, edge_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_flag_q, par_flag_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;
  logic                  serr_q, serr_d;
  logic                  sampled_bit;
  logic                  decide;
  logic                  wrap;

  uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
    .CLK         (CLK),
    .RST         (RST),
    .edge_cnt    (edge_q),
    .presc       (presc_q),
    .RX_IN       (RX_IN),
    .sampled_bit (sampled_bit),
    .decide      (decide)
  );

  assign wrap = (edge_q == presc_q - PRESC_W'(1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      edge_q     <= '0;
      presc_q    <= PRESC_W'(PRESC_DEFAULT);
      bit_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      par_flag_q <= 1'b0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      presc_q    <= presc_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      par_flag_q <= par_flag_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    edge_d     = edge_q;
    presc_d    = presc_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    data_d     = data_q;
    par_flag_d = par_flag_q;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    serr_d     = 1'b0;

    if (state_q != IDLE) begin
      edge_d = wrap ? '0 : edge_q + PRESC_W'(1);
    end

    case (state_q)
      IDLE: begin
        // Prescale is captured only here, so it may change freely mid-frame.
        if (!RX_IN) begin
          state_d    = START;
          edge_d     = '0;
          bit_d      = '0;
          par_flag_d = 1'b0;
          presc_d    = prescale_legal(32'(Prescale)) ? Prescale : PRESC_W'(PRESC_DEFAULT);
        end
      end
      START: begin
        if (wrap) state_d = sampled_bit ? IDLE : DATA;
      end
      DATA: begin
        if (decide) shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
        if (wrap) begin
          bit_d = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(DATA_WIDTH - 1)) state_d = PAR_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (wrap) begin
          if (sampled_bit != (^shift_q ^ PAR_TYP)) par_flag_d = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        // A bad stop bit outranks a parity error; only a clean frame updates P_DATA.
        if (wrap) begin
          state_d = IDLE;
          if (!sampled_bit) begin
            serr_d = 1'b1;
          end else if (par_flag_q) begin
            perr_d = 1'b1;
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign P_DATA     = data_q;
  assign data_valid = valid_q;
  assign par_err    = perr_q;
  assign stp_err    = serr_q;
  assign busy       = (state_q != IDLE);

endmodule
